// File: rtl/stage_id.sv
// Instruction-decode stage: register file, control decoder, sign extender and load-use hazard unit.
// Optional ID_WB_BYPASS_EN forwards a same-cycle write-back to the A/B read ports.
module stage_id #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_in,
    input  logic [WIDTH-1:0] nPC_in,
    input  logic             wb_RegWrite,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             idex_MemRead,
    input  logic [4:0]       idex_RT,
    output logic [WIDTH-1:0] nPC_out,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic [WIDTH-1:0] SE_out,
    output logic [4:0]       RT_out,
    output logic [4:0]       RD_out,
    output logic [1:0]       ALUOp_out,
    output logic             ALUSrc_out,
    output logic             Branch_out,
    output logic             MemRead_out,
    output logic             MemWrite_out,
    output logic             MemtoReg_out,
    output logic             RegWrite_out,
    output logic             RegDst_out,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic [5:0]       opcode_s;
    logic [4:0]       rs_s;
    logic [4:0]       rt_s;
    logic [WIDTH-1:0] rs_val_s;
    logic [WIDTH-1:0] rt_val_s;
    logic             hz_s;
    // {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
    logic [8:0]       ctrl_s;
    logic [8:0]       ctrl_gated_s;

    assign opcode_s = instr_in[31:26];
    assign rs_s     = instr_in[25:21];
    assign rt_s     = instr_in[20:16];

    // Register file write port; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_RegWrite && (wb_addr != 5'd0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Asynchronous read ports with optional same-cycle write-back forwarding.
    always_comb begin
        rs_val_s = '0;
        rt_val_s = '0;
        if (rs_s != 5'd0) begin
            rs_val_s = regs_q[rs_s];
        end else begin
            rs_val_s = '0;
        end
        if (rt_s != 5'd0) begin
            rt_val_s = regs_q[rt_s];
        end else begin
            rt_val_s = '0;
        end
`ifdef ID_WB_BYPASS_EN
        if (wb_RegWrite && (wb_addr != 5'd0) && (wb_addr == rs_s)) begin
            rs_val_s = wb_data;
        end else begin
            rs_val_s = rs_val_s;
        end
        if (wb_RegWrite && (wb_addr != 5'd0) && (wb_addr == rt_s)) begin
            rt_val_s = wb_data;
        end else begin
            rt_val_s = rt_val_s;
        end
`endif
    end

    // Main control decoder; unknown opcodes decode as a NOP.
    always_comb begin
        ctrl_s = 9'b0_0000_0000;
        case (opcode_s)
            OP_RTYPE: ctrl_s = 9'b1_0010_0010;
            OP_LW:    ctrl_s = 9'b0_1111_0000;
            OP_SW:    ctrl_s = 9'b0_1000_1000;
            OP_BEQ:   ctrl_s = 9'b0_0000_0101;
            default:  ctrl_s = 9'b0_0000_0000;
        endcase
    end

    // rt is compared for every opcode, which is conservative but never misses a hazard.
    assign hz_s = idex_MemRead && (idex_RT != 5'd0) &&
                  ((idex_RT == rs_s) || (idex_RT == rt_s));

    // Bubble insertion: a hazard zeroes every control bit.
    always_comb begin
        ctrl_gated_s = 9'b0_0000_0000;
        if (hz_s) begin
            ctrl_gated_s = 9'b0_0000_0000;
        end else begin
            ctrl_gated_s = ctrl_s;
        end
    end

    // Saturating stall counter next-state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign nPC_out      = nPC_in;
    assign A_out        = rs_val_s;
    assign B_out        = rt_val_s;
    assign SE_out       = {{(WIDTH-16){instr_in[15]}}, instr_in[15:0]};
    assign RT_out       = instr_in[20:16];
    assign RD_out       = instr_in[15:11];
    assign RegDst_out   = ctrl_gated_s[8];
    assign ALUSrc_out   = ctrl_gated_s[7];
    assign MemtoReg_out = ctrl_gated_s[6];
    assign RegWrite_out = ctrl_gated_s[5];
    assign MemRead_out  = ctrl_gated_s[4];
    assign MemWrite_out = ctrl_gated_s[3];
    assign Branch_out   = ctrl_gated_s[2];
    assign ALUOp_out    = ctrl_gated_s[1:0];
    assign PCWrite      = !hz_s;
    assign IFIDWrite    = !hz_s;
    assign stall_cnt    = stall_cnt_q;

endmodule
